// File: rtl/cache_line_responder_pkg.sv
// Shared types and constants for the cache line-burst responder.
// The LFSR helpers are only referenced when CACHE_RESP_WAITSTATE_EN is defined.
package cache_line_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DATA, ACK} resptype;

  localparam logic [6:0] LFSR_SEED = 7'h5A;
  // x^7 + x^6 + 1: feedback is the XOR of the two top bits
  localparam logic [6:0] LFSR_TAPS = 7'b110_0000;

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cache_line_responder_respmem.sv
// Beat-wide backing store for the responder: combinational read, registered
// write, no reset (contents are undefined until written).
module respmem
  import cache_line_responder_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cache_line_responder.sv
// Line-burst responder standing in for bus interface + memory under one cache.
// Optional random wait states on DATA beats: define CACHE_RESP_WAITSTATE_EN.
//
// state | meaning
// IDLE  | waiting for a nonzero CacheBusRW; latches direction and base index
// WAIT  | first-beat latency countdown
// DATA  | one beat per advancing cycle, fetch or writeback
// ACK   | one-cycle completion pulse, CacheBusRW ignored
module cache_line_responder
  import cache_line_responder_pkg::*;
#(
  parameter int PA_BITS  = 34,
  parameter int LINELEN  = 512,
  parameter int BEATLEN  = 64,
  parameter int LOGBWPL  = $clog2(LINELEN/BEATLEN),
  parameter int MEMWORDS = 4096,
  parameter int LATENCY  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [BEATLEN-1:0] WriteBeatData,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               SelBusBeat,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               CacheBusAck
);

  localparam int BEATS   = LINELEN / BEATLEN;
  localparam int MEMAW   = $clog2(MEMWORDS);
  localparam int BYTEOFF = $clog2(BEATLEN / 8);
  localparam int LATW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LATW-1:0]  LAT_LOAD  = LATW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [MEMAW-1:0] LINE_MASK = ~MEMAW'(BEATS - 1);

  resptype            state, state_next;
  logic               is_write;
  logic [MEMAW-1:0]   base;
  logic [MEMAW-1:0]   req_idx;
  logic [LATW-1:0]    lat_cnt;
  logic               stall;
  logic               advance;
  logic               last_beat;
  logic               mem_we;
  logic [MEMAW-1:0]   mem_addr;
  logic [BEATLEN-1:0] mem_rdata;

`ifdef CACHE_RESP_WAITSTATE_EN
  logic [6:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_step(lfsr);
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign req_idx   = MEMAW'(CacheBusAdr >> BYTEOFF);
  assign advance   = (state == DATA) && !stall;
  assign last_beat = (BeatCount == LOGBWPL'(BEATS - 1));
  // base is line-aligned, so OR-ing the beat index cannot carry past the line
  assign mem_addr  = base | MEMAW'(BeatCount);
  // reset gates the write so an aborted burst stops on the reset cycle itself
  assign mem_we    = advance && is_write && !reset;

  respmem #(.WORDS(MEMWORDS), .WIDTH(BEATLEN)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (WriteBeatData),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      BeatCount   <= '0;
      FetchBuffer <= '0;
      is_write    <= 1'b0;
      base        <= '0;
      lat_cnt     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && CacheBusRW != 2'b00) begin
        is_write <= CacheBusRW[0];
        base     <= req_idx & LINE_MASK;
        lat_cnt  <= LAT_LOAD;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (advance) begin
        BeatCount <= last_beat ? '0 : BeatCount + 1'b1;
        if (!is_write) FetchBuffer[BeatCount*BEATLEN +: BEATLEN] <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next  = state;
    SelBusBeat  = 1'b0;
    CacheBusAck = 1'b0;
    case (state)
      IDLE: if (CacheBusRW != 2'b00) state_next = (LATENCY == 0) ? DATA : WAIT;
      WAIT: if (lat_cnt == '0) state_next = DATA;
      DATA: begin
        SelBusBeat = 1'b1;
        if (advance && last_beat) state_next = ACK;
      end
      ACK: begin
        CacheBusAck = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_responder.sv
// Directed bench for cache_line_responder: vector table of line transfers plus
// hand sequences for RW drop, RW held through ACK and reset mid-writeback.
module tb_cache_line_responder;

  localparam int LAT   = 2;
  localparam int BEATS = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   CacheBusRW;
  logic [33:0]  CacheBusAdr;
  logic [63:0]  WriteBeatData;
  logic [2:0]   BeatCount;
  logic         SelBusBeat;
  logic [511:0] FetchBuffer;
  logic         CacheBusAck;

  int n_checks = 0;
  int n_fail   = 0;
  int wb_kind  = 0;

  cache_line_responder dut (
    .clk           (clk),
    .reset         (reset),
    .CacheBusRW    (CacheBusRW),
    .CacheBusAdr   (CacheBusAdr),
    .WriteBeatData (WriteBeatData),
    .BeatCount     (BeatCount),
    .SelBusBeat    (SelBusBeat),
    .FetchBuffer   (FetchBuffer),
    .CacheBusAck   (CacheBusAck)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int kind, input int k);
    case (kind)
      0:       return 64'(17 * (k + 1));
      1:       return 64'hA5A5_A5A5_A5A5_A5A5 ^ 64'(k);
      2:       return 64'hC0DE_0000_0000_0000 | 64'(k);
      3:       return 64'hD00D_0000_0000_0000 | 64'(k);
      default: return 64'hBEEF_0000_0000_0000 | 64'(k);
    endcase
  endfunction

  function automatic logic [511:0] line_of(input int kind);
    logic [511:0] l;
    for (int k = 0; k < BEATS; k++) l[k*64 +: 64] = pat(kind, k);
    return l;
  endfunction

  // cache side: supply the beat the responder is currently selecting
  assign WriteBeatData = pat(wb_kind, int'(BeatCount));

`ifdef CACHE_RESP_WAITSTATE_EN
  logic [6:0] lfsr_m;
  always @(posedge clk) begin
    if (reset) lfsr_m <= 7'h5A;
    else       lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
  end
`endif

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called just after a negedge. off = idle cycles before the request is sampled.
  task automatic xfer(input logic [1:0] rw, input logic [33:0] adr, input int wkind,
                      input int drop_n, input bit hold, input int off,
                      output int ack_n, output int stalls);
    int  n, done;
    bit  acked, stall;
    logic       e_ack, e_sel;
    logic [2:0] e_bc;
    wb_kind = wkind;
    CacheBusRW = rw;
    CacheBusAdr = adr;
    n = 0; done = 0; acked = 0; ack_n = -1; stalls = 0;
    while (!acked && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == drop_n) CacheBusRW = 2'b00;
      e_ack = 1'b0; e_sel = 1'b0; e_bc = 3'd0;
      if (n >= LAT + 1 + off && done < BEATS) begin
        e_sel = 1'b1;
        e_bc  = done[2:0];
`ifdef CACHE_RESP_WAITSTATE_EN
        stall = lfsr_m[0];
`else
        stall = 1'b0;
`endif
        if (stall) stalls++;
        else done++;
      end else if (done == BEATS) begin
        e_ack = 1'b1;
        acked = 1'b1;
        ack_n = n;
      end
      check("cycle_ack_sel_bc", {CacheBusAck, SelBusBeat, BeatCount}, {e_ack, e_sel, e_bc});
    end
    if (!acked) check("xfer_timeout", 0, 1);
    if (!hold) CacheBusRW = 2'b00;
  endtask

  typedef struct {
    logic [1:0]  rw;
    logic [33:0] adr;
    int          wkind;
    int          ekind;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ack_n, st, found;
    logic [511:0] last_line, mixed;
    bit ack_seen;

    vecs[0] = '{2'b01, 34'h1000, 0, 0};
    vecs[1] = '{2'b10, 34'h1000, 0, 0};
    vecs[2] = '{2'b10, 34'h1038, 0, 0};
    vecs[3] = '{2'b10, 34'h9000, 0, 0};
    vecs[4] = '{2'b11, 34'h2000, 1, 1};
    vecs[5] = '{2'b10, 34'h2000, 0, 1};
    vecs[6] = '{2'b01, 34'h3000, 2, 2};
    vecs[7] = '{2'b01, 34'h7FC0, 3, 3};
    vecs[8] = '{2'b10, 34'hFFC0, 0, 3};

    reset = 1'b1;
    CacheBusRW = 2'b00;
    CacheBusAdr = '0;
    last_line = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {CacheBusAck, SelBusBeat, BeatCount, FetchBuffer}, '0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i].rw, vecs[i].adr, vecs[i].wkind, 0, 1'b0, 0, ack_n, st);
      check("ack_cycle", ack_n, 11 + st);
      if (!vecs[i].rw[0]) last_line = line_of(vecs[i].ekind);
      check("fetch_line", FetchBuffer, last_line);
      @(posedge clk); @(negedge clk);
      check("fetch_line_held", FetchBuffer, last_line);
    end

    // RW dropped mid-burst: committed transfer still completes
    xfer(2'b10, 34'h1000, 0, 3, 1'b0, 0, ack_n, st);
    check("drop_ack_cycle", ack_n, 11 + st);
    check("drop_line", FetchBuffer, line_of(0));
    @(posedge clk); @(negedge clk);

    // RW held through ACK: ignored in ACK, resampled in the following IDLE
    xfer(2'b10, 34'h2000, 0, 0, 1'b1, 0, ack_n, st);
    check("hold_ack_cycle", ack_n, 11 + st);
    check("hold_line", FetchBuffer, line_of(1));
    xfer(2'b10, 34'h1000, 0, 0, 1'b0, 1, ack_n, st);
    check("restart_ack_cycle", ack_n, 12 + st);
    check("restart_line", FetchBuffer, line_of(0));
    @(posedge clk); @(negedge clk);

    // reset during writeback beat 3 of a line holding pattern 2
    wb_kind = 4;
    CacheBusRW = 2'b01;
    CacheBusAdr = 34'h3000;
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (SelBusBeat && BeatCount == 3'd3) found = 1;
    end
    check("reach_beat3", found, 1);
    reset = 1'b1;
    CacheBusRW = 2'b00;
    @(posedge clk); @(negedge clk);
    check("abort_outputs", {CacheBusAck, SelBusBeat, BeatCount, FetchBuffer}, '0);
    reset = 1'b0;
    ack_seen = 1'b0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      ack_seen |= CacheBusAck;
    end
    check("no_ack_after_abort", ack_seen, 1'b0);
    for (int k = 0; k < BEATS; k++) mixed[k*64 +: 64] = (k < 3) ? pat(4, k) : pat(2, k);
    xfer(2'b10, 34'h3000, 0, 0, 1'b0, 0, ack_n, st);
    check("abort_ack_cycle", ack_n, 11 + st);
    check("abort_line", FetchBuffer, mixed);
    @(posedge clk); @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_line_responder.md
# cache_line_responder

Line-burst responder for the cache bus interface: answers `CacheBusRW` line fetches and dirty-line writebacks issued by the I$/D$ cache FSM, driving `BeatCount`, `SelBusBeat`, `FetchBuffer` and `CacheBusAck` back to the cache. It contains a beat-wide backing memory and a fixed first-beat latency, so it can stand in for the bus interface plus memory in cache-level benches and small FPGA configurations. It sits directly below one cache instance, one responder per cache.

## Interface
- `PA_BITS`, 34, physical address width
- `LINELEN`, 512, cache line width in bits
- `BEATLEN`, 64, bus beat width in bits; `BEATS = LINELEN/BEATLEN`
- `LOGBWPL`, `$clog2(LINELEN/BEATLEN)`, beat counter width
- `MEMWORDS`, 4096, backing memory depth in beats; power of two, multiple of `BEATS`
- `LATENCY`, 2, wait cycles before the first beat; 0 is legal

- `clk` in 1: clock
- `reset` in 1: one clock; reset is synchronous and active-high
- `CacheBusRW` in 2: [1] line fetch, [0] line writeback; 2'b11 is treated as a writeback
- `CacheBusAdr` in `PA_BITS`: line address; offset bits ignored
- `WriteBeatData` in `BEATLEN`: writeback beat from the cache, selected by `BeatCount`
- `BeatCount` out `LOGBWPL`: current beat index
- `SelBusBeat` out 1: cache must select its word by `BeatCount`
- `FetchBuffer` out `LINELEN`: assembled fetched line
- `CacheBusAck` out 1: one-cycle pulse, transfer complete

## Operation
- FSM states: IDLE, WAIT, DATA, ACK.
- IDLE: if `CacheBusRW != 0`, latch direction and base index, then go to WAIT. If `LATENCY == 0`, go straight to DATA. Base index = `(CacheBusAdr >> $clog2(BEATLEN/8)) mod MEMWORDS`, with the low `LOGBWPL` bits cleared.
- WAIT: latency counter runs from `LATENCY-1` down to 0, then moves to DATA.
- DATA: `SelBusBeat = 1`. Every advancing cycle performs one of:
  - Fetch: `FetchBuffer[BeatCount*BEATLEN +: BEATLEN] <= mem[base+BeatCount]`.
  - Writeback: `mem[base+BeatCount] <= WriteBeatData`.
  - After the beat, `BeatCount` increments. After beat `BEATS-1`, go to ACK and wrap `BeatCount` to 0.
- ACK: `CacheBusAck = 1` for exactly one cycle. `FetchBuffer` is valid and stable here and is held until the next fetch writes it. `CacheBusRW` is ignored in ACK. Next state is IDLE.
- Once it leaves IDLE, a transfer completes regardless of `CacheBusRW` (a FlushStage kill does not abort a committed burst).
- If `CacheBusRW` is still nonzero in IDLE the cycle after ACK, a new transfer starts.
- A line never straddles the memory end; the index wraps modulo `MEMWORDS`.
- Reset values: state IDLE; `CacheBusAck` 0; `BeatCount` 0; `SelBusBeat` 0; `FetchBuffer` 0. Memory is not reset.
- Reset mid-transfer: abort immediately. Beats already written stay; no further writes occur and no ack is issued.

## Timing
- Request sampled in IDLE at cycle t0:
  - WAIT occupies t0+1 .. t0+LATENCY.
  - DATA occupies t0+LATENCY+1 .. t0+LATENCY+BEATS.
  - Ack at t0+LATENCY+BEATS+1 (t0+11 with defaults).
- Memory read is combinational within the DATA cycle; memory write is registered at the end of the DATA cycle.
- `WriteBeatData` must be valid in the same cycle as the corresponding `BeatCount`.
- Back-to-back transfers (e.g. writeback then fetch) have a minimum gap of one IDLE cycle after ACK.

## Configuration
- `CACHE_RESP_WAITSTATE_EN` defined:
  - A 7-bit Fibonacci LFSR (x^7+x^6+1, seed 7'h5A at reset) steps every cycle.
  - A DATA cycle with `LFSR[0] == 1` is a stall: no memory access, `BeatCount` held, `SelBusBeat` stays 1.
  - Ack is delayed by the number of stall cycles; data results are identical.
- Undefined: every DATA cycle advances and the LFSR is not built.

## Structure
- Shared package: the state enum `resptype` (IDLE, WAIT, DATA, ACK) and the LFSR seed/tap constants.
- One sub-module, `respmem`: a `MEMWORDS`×`BEATLEN` single-port array with a combinational read, a synchronous write enable, and no reset.
- FSM, latency counter, beat counter, LFSR and `FetchBuffer` register live in `cache_line_responder`.

## Test plan
- Writeback RW=01 to 0x1000 with beats 0x11..0x88 (beat k = 0x11*(k+1)), then fetch RW=10 from 0x1000 → `FetchBuffer` beat k = 0x11*(k+1); ack exactly at t0+11 for each transfer.
- Fetch from 0x1038 after the above → same line as 0x1000 (offset ignored); fetch from 0x1000 + MEMWORDS*8 → same line (wrap).
- Drop `CacheBusRW` to 0 at t0+3 of a fetch → transfer completes and ack still pulses at t0+11; hold RW=10 through ACK → no restart in ACK, new transfer sampled the cycle after ACK.
- RW=11 to 0x2000 with data 0xA5.. → memory written (writeback priority); a following fetch returns 0xA5 pattern.
- Assert reset during writeback DATA beat 3 (beats 0–2 already written) → beats 0–2 hold new data, beats 3–7 keep old contents; all outputs 0 the next cycle; no ack.
- With `CACHE_RESP_WAITSTATE_EN`: repeat the first scenario → identical `FetchBuffer`; ack cycle = t0+11+(number of LFSR stall cycles counted by the bench model); `BeatCount` never skips a value.
